// File: rtl/tcount_seq_if.sv
// Bundle of count-control and count-status signals between a controller and tcount_seq.
// Latency: none; wires only.
// Backpressure: none; en/load are sampled every clock, with no ready path.
// Ports (master = controller side, slave = counter side):
//   en, up, load, d        controller -> counter
//   q, t, tc, wrap         counter -> controller
//   oneshot / done         only present when TCOUNT_ONESHOT_EN is defined
interface tcount_seq_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             tc;
  logic             wrap;
`ifdef TCOUNT_ONESHOT_EN
  logic             oneshot;
  logic             done;
`endif

  modport master (
    output en, up, load, d,
    input  q, t, tc, wrap
`ifdef TCOUNT_ONESHOT_EN
    , output oneshot
    , input  done
`endif
  );

  modport slave (
    input  en, up, load, d,
    output q, t, tc, wrap
`ifdef TCOUNT_ONESHOT_EN
    , input  oneshot
    , output done
`endif
  );
endinterface

// File: rtl/tcount_seq.sv
// Modulo up/down counter with parallel load; emits the per-bit toggle vector for a T-flop bank.
// Latency: q and wrap update one edge after inputs are sampled; t and tc are combinational.
// Backpressure: none; the counter acts on en/load every cycle.
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-high clear (q=0, wrap=0, done=0)
//   bus.en/up    count enable / direction (1 = up)
//   bus.load/d   synchronous load; d above MODULO-1 saturates to MODULO-1
//   bus.q        registered count
//   bus.t        q ^ next q, drives an external T flip-flop bank
//   bus.tc       terminal count: en & ~load & (up ? q==MODULO-1 : q==0)
//   bus.wrap     one-cycle pulse in the cycle after a wrap edge
// Optional build macro TCOUNT_ONESHOT_EN adds bus.oneshot / bus.done:
//   with oneshot=1 the counter stops at terminal count instead of wrapping
//   and stays frozen with done=1 until load or clr.
// Parameter constraints: 2 <= WIDTH <= 16, 2 <= MODULO <= 2**WIDTH.
module tcount_seq #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic         clk,
  input  logic         clr,
  tcount_seq_if.slave  bus
);

  // One extra bit so MODULO == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   mod_ext = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] max_val = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] one     = WIDTH'(1);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;

  assign en   = bus.en;
  assign up   = bus.up;
  assign load = bus.load;
  assign d    = bus.d;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap;
  logic             wrap_nxt;
  logic             tc_hit;
  logic             tc;
  logic             out_of_range;
  logic             frozen;
  logic             stop;

`ifdef TCOUNT_ONESHOT_EN
  typedef enum logic {
    st_run  = 1'b0,
    st_done = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   oneshot;

  assign oneshot = bus.oneshot;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= st_run;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    frozen    = (state == st_done);
    // Terminal count with oneshot set parks the counter rather than wrapping.
    stop      = oneshot & tc & ~frozen;
    state_nxt = state;
    if (load) begin
      state_nxt = st_run;
    end else if (stop) begin
      state_nxt = st_done;
    end
  end

  assign bus.done = (state == st_done);
`else
  assign frozen = 1'b0;
  assign stop   = 1'b0;
`endif

  // Only reachable through a corrupted register; recover on the next count.
  assign out_of_range = ({1'b0, q} >= mod_ext);

  assign tc_hit = up ? (q == max_val) : (q == '0);
  assign tc     = en & ~load & tc_hit;

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = (d > max_val) ? max_val : d;
    end else if (en && !frozen) begin
      if (out_of_range) begin
        q_nxt = '0;
      end else if (stop) begin
        q_nxt = q;
      end else if (up) begin
        q_nxt = (q == max_val) ? '0 : (q + one);
      end else begin
        q_nxt = (q == '0) ? max_val : (q - one);
      end
      // A wrap is only an edge that actually rolled over; loads never count.
      wrap_nxt = tc & ~stop;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign bus.q    = q;
  assign bus.t    = q ^ q_nxt;
  assign bus.tc   = tc;
  assign bus.wrap = wrap;

endmodule

// File: tb/tb_tcount_seq.sv
// Directed and short randomized bench for tcount_seq at WIDTH=4, MODULO=10.
// Latency: checks q/wrap 1 time unit after each rising edge, t/tc before it.
// Backpressure: not applicable.
module tb_tcount_seq;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  tcount_seq_if #(.WIDTH(4)) bus ();

  tcount_seq #(
    .WIDTH (4),
    .MODULO(10)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference bank of T flip-flops with active-low clear driven from ~clr.
  logic       bank_clr_n;
  logic [3:0] bank;
  assign bank_clr_n = ~clr;
  always_ff @(posedge clk or negedge bank_clr_n) begin
    if (!bank_clr_n) bank <= 4'd0;
    else             bank <= bank ^ bus.t;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_nxt(input logic [3:0] cq, input logic e,
                                           input logic u, input logic l,
                                           input logic [3:0] dd);
    if (l) return (dd > 4'd9) ? 4'd9 : dd;
    if (!e) return cq;
    if (u) return (cq == 4'd9) ? 4'd0 : cq + 4'd1;
    return (cq == 4'd0) ? 4'd9 : cq - 4'd1;
  endfunction

  function automatic logic model_tc(input logic [3:0] cq, input logic e,
                                    input logic u, input logic l);
    return e & ~l & (u ? (cq == 4'd9) : (cq == 4'd0));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] mq;
    logic [3:0] exp_n;
    logic       exp_tc;
    logic       mwrap;

    total = 0;
    bad   = 0;
    clr       = 1'b1;
    bus.en    = 1'b0;
    bus.up    = 1'b1;
    bus.load  = 1'b0;
    bus.d     = 4'd0;
`ifdef TCOUNT_ONESHOT_EN
    bus.oneshot = 1'b0;
`endif
    #3;
    chk("rst_q", bus.q, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_t", bus.t, 0);
    chk("rst_tc", bus.tc, 0);
`ifdef TCOUNT_ONESHOT_EN
    chk("rst_done", bus.done, 0);
`endif
    tick();
    tick();
    clr = 1'b0;

    // Asynchronous clear between edges from q=9.
    bus.load = 1'b1; bus.d = 4'd9;
    tick();
    chk("ld9_q", bus.q, 9);
    bus.load = 1'b0;
    #2 clr = 1'b1;
    #1;
    chk("aclr_q", bus.q, 0);
    chk("aclr_wrap", bus.wrap, 0);
    chk("aclr_bank", bank, 0);
    clr = 1'b0;
    bus.en = 1'b1; bus.up = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("post_clr_q", bus.q, i);
    end

    // Up wrap 8 -> 9 -> 0.
    bus.load = 1'b1; bus.d = 4'd8;
    tick();
    chk("ld8_q", bus.q, 8);
    chk("ld8_wrap", bus.wrap, 0);
    bus.load = 1'b0;
    #1;
    chk("up8_t", bus.t, 4'b0001);
    chk("up8_tc", bus.tc, 0);
    tick();
    chk("up_q9", bus.q, 9);
    chk("up9_tc", bus.tc, 1);
    chk("up9_t", bus.t, 4'b1001);
    tick();
    chk("upwrap_q", bus.q, 0);
    chk("upwrap_w", bus.wrap, 1);
    tick();
    chk("upwrap_q1", bus.q, 1);
    chk("upwrap_w0", bus.wrap, 0);

    // Down wrap 0 -> 9 -> 8.
    bus.load = 1'b1; bus.d = 4'd0;
    tick();
    chk("ld0_q", bus.q, 0);
    bus.load = 1'b0; bus.up = 1'b0;
    #1;
    chk("dn0_tc", bus.tc, 1);
    chk("dn0_t", bus.t, 4'b1001);
    tick();
    chk("dnwrap_q", bus.q, 9);
    chk("dnwrap_w", bus.wrap, 1);
    tick();
    chk("dn_q8", bus.q, 8);
    chk("dn_w0", bus.wrap, 0);

    // Load wins over count and saturates; load never flags a wrap.
    bus.up = 1'b1; bus.load = 1'b1; bus.d = 4'hE;
    #1;
    chk("ldsat_tc", bus.tc, 0);
    tick();
    chk("ldsat_q", bus.q, 9);
    chk("ldsat_w", bus.wrap, 0);
    bus.d = 4'd3;
    #1;
    chk("ld3_tc", bus.tc, 0);
    chk("ld3_t", bus.t, 4'b1010);
    tick();
    chk("ld3_q", bus.q, 3);
    chk("ld3_w", bus.wrap, 0);

    // Hold for five edges.
    bus.load = 1'b0; bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_t", bus.t, 0);
      chk("hold_tc", bus.tc, 0);
      tick();
      chk("hold_q", bus.q, 3);
    end

    // Direction change takes effect at the next edge.
    bus.en = 1'b1; bus.up = 1'b1;
    tick();
    chk("dir_up", bus.q, 4);
    bus.up = 1'b0;
    tick();
    chk("dir_dn", bus.q, 3);
    chk("bank_pre", bank, 3);

    // Randomized run against the model and the T flip-flop bank.
    mq    = 4'd3;
    mwrap = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.en   = 1'($urandom_range(0, 1));
      bus.up   = 1'($urandom_range(0, 1));
      bus.load = ($urandom_range(0, 3) == 0);
      bus.d    = 4'($urandom_range(0, 15));
      #1;
      exp_n  = model_nxt(mq, bus.en, bus.up, bus.load, bus.d);
      exp_tc = model_tc(mq, bus.en, bus.up, bus.load);
      chk("rnd_t", bus.t, mq ^ exp_n);
      chk("rnd_tc", bus.tc, exp_tc);
      tick();
      mq    = exp_n;
      mwrap = exp_tc;
      chk("rnd_q", bus.q, mq);
      chk("rnd_wrap", bus.wrap, mwrap);
      chk("rnd_bank", bank, mq);
    end

`ifdef TCOUNT_ONESHOT_EN
    // One-shot: stop at 9, freeze, restart on load.
    bus.en = 1'b1; bus.up = 1'b1; bus.oneshot = 1'b1;
    bus.load = 1'b1; bus.d = 4'd7;
    tick();
    chk("os_ld7", bus.q, 7);
    bus.load = 1'b0;
    tick();
    chk("os_q8", bus.q, 8);
    tick();
    chk("os_q9", bus.q, 9);
    #1;
    chk("os_stop_t", bus.t, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("os_hold_q", bus.q, 9);
      chk("os_done", bus.done, 1);
      chk("os_wrap", bus.wrap, 0);
      chk("os_bank", bank, 9);
    end
    bus.load = 1'b1; bus.d = 4'd2;
    tick();
    chk("os_ld2", bus.q, 2);
    chk("os_done0", bus.done, 0);
    bus.load = 1'b0;
    tick();
    chk("os_q3", bus.q, 3);
    chk("os_done_run", bus.done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
